// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
// Instruction fields follow the RV32 base encoding.
package mem_access_stage_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] data_t;

  typedef struct packed {
    logic [16:0] upper;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } instr_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    DRAIN,
    DONE
  } mem_state_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic                mem_req;
  logic                mem_we;
  data_t               mem_addr;
  logic [XLEN/8-1:0]   mem_be;
  data_t               mem_wdata;
  logic                mem_gnt;
  logic                mem_rvalid;
  data_t               mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_access_stage_load_formatter.sv
// Load lane extraction: picks the byte/halfword at addr[1:0] and extends it
// according to funct3. Purely combinational.
module mem_access_stage_load_formatter
  import mem_access_stage_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  data_t      rdata,
  output data_t      data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'(rdata >> {addr_lo, 3'b000});
    lane_h = 16'(rdata >> {addr_lo[1], 4'b0000});
    case (funct3)
      F3_B:    data = {{24{lane_b[7]}}, lane_b};
      F3_H:    data = {{16{lane_h[15]}}, lane_h};
      F3_BU:   data = {24'd0, lane_b};
      F3_HU:   data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: one bus transaction per load/store, store lane
// alignment, load formatting and pipeline stall generation.
//
// state       | meaning
// IDLE        | no access outstanding; issues a new one when pending
// WAIT_GNT    | request asserted, waiting for the bus to accept it
// WAIT_RVALID | load accepted, waiting for read data
// DRAIN       | flushed load accepted; swallow its read data
// DONE        | access finished (or timed out) but pipeline not yet advanced
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      en,
  input  instr_t                    instr_in,
  input  logic                      instr_valid_in,
  input  data_t                     alu_result_in,
  input  data_t                     store_data_in,
  mem_access_stage_if.master        bus,
  output data_t                     mem_data_out,
  output data_t                     mem_addr_out,
  output logic                      stall_out,
  output logic                      misaligned_out,
  output logic                      bus_err_out
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  mem_state_t  state;
  logic [CW-1:0] tmo_cnt;
  data_t       hold;
  logic [2:0]  f3_q;
  logic [1:0]  addr_lo_q;
  logic        store_q;

  logic        is_load, is_store, access, misaligned, pending, timeout;
  logic [2:0]  f3;
  logic [1:0]  addr_lo;
  logic        req, stall;
  logic [3:0]  be;
  data_t       wdata, fmt_data;
  logic        unused_instr_bits;

  assign unused_instr_bits = ^{instr_in.upper, instr_in.rd};

  assign f3         = instr_in.funct3;
  assign addr_lo    = alu_result_in[1:0];
  assign is_load    = instr_in.opcode == OP_LOAD;
  assign is_store   = instr_in.opcode == OP_STORE;
  assign access     = instr_valid_in & (is_load | is_store);
  assign misaligned = ((f3[1:0] == 2'b01) & addr_lo[0]) |
                      ((f3[1:0] == 2'b10) & (addr_lo != 2'b00));
  assign pending    = access & ~misaligned & ~flush;
  assign timeout    = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_LAST);

  // Formatting always uses the copies latched at issue, not the live inputs.
  mem_access_stage_load_formatter u_fmt (
    .funct3  (f3_q),
    .addr_lo (addr_lo_q),
    .rdata   (bus.mem_rdata),
    .data    (fmt_data)
  );

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data_in[7:0]}};
      end
      2'b01: begin
        be    = 4'b0011 << addr_lo;
        wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = store_data_in;
      end
    endcase
  end

  always_comb begin
    req   = 1'b0;
    stall = 1'b0;
    case (state)
      IDLE: begin
        req   = pending;
        stall = pending & ~(is_store & bus.mem_gnt);
      end
      WAIT_GNT: begin
        req   = 1'b1;
        stall = ~(store_q & bus.mem_gnt);
      end
      WAIT_RVALID: stall = ~bus.mem_rvalid;
      DRAIN:       stall = 1'b1;
      default:     stall = 1'b0;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of inputs.
  assign bus.mem_req     = rst_n & req;
  assign bus.mem_we      = rst_n & is_store;
  assign bus.mem_addr    = rst_n ? {alu_result_in[XLEN-1:2], 2'b00} : '0;
  assign bus.mem_be      = rst_n ? be : '0;
  assign bus.mem_wdata   = rst_n ? wdata : '0;
  assign stall_out       = rst_n & stall;
  assign misaligned_out  = rst_n & (state == IDLE) & access & misaligned;
  assign mem_addr_out    = rst_n ? alu_result_in : '0;
  assign mem_data_out    = (rst_n && state == WAIT_RVALID && bus.mem_rvalid) ? fmt_data :
                           (rst_n ? hold : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      hold        <= '0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      store_q     <= 1'b0;
      bus_err_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) bus_err_out <= 1'b0;
          if (pending) begin
            f3_q      <= f3;
            addr_lo_q <= addr_lo;
            store_q   <= is_store;
            tmo_cnt   <= '0;
            if (bus.mem_gnt) begin
              if (is_store) state <= en ? IDLE : DONE;
              else          state <= WAIT_RVALID;
            end else begin
              state <= WAIT_GNT;
            end
          end
        end
        WAIT_GNT: begin
          if (bus.mem_gnt) begin
            if (store_q) begin
              state <= en ? IDLE : DONE;
            end else begin
              tmo_cnt <= '0;
              state   <= flush ? DRAIN : WAIT_RVALID;
            end
          end else if (flush) begin
            state <= IDLE;
          end else if (timeout) begin
            bus_err_out <= 1'b1;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_RVALID: begin
          if (bus.mem_rvalid) begin
            hold  <= fmt_data;
            state <= en ? IDLE : DONE;
          end else if (flush) begin
            state <= DRAIN;
          end else if (timeout) begin
            bus_err_out <= 1'b1;
            hold        <= '0;
            state       <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.mem_rvalid) state <= IDLE;
        end
        DONE: begin
          if (en) begin
            bus_err_out <= 1'b0;
            state       <= IDLE;
          end else if (flush) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: stores, loads, misalignment, delayed
// grant with held pipeline, flush/drain, timeout and asynchronous reset.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n, flush, en, instr_valid_in;
  instr_t instr_in;
  data_t  alu_result_in, store_data_in, mem_data_out, mem_addr_out;
  logic   stall_out, misaligned_out, bus_err_out;

  int n_chk   = 0;
  int n_pass  = 0;
  int hs_cnt  = 0;
  int hs_base = 0;

  mem_access_stage_if bus_if ();

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .en             (en),
    .instr_in       (instr_in),
    .instr_valid_in (instr_valid_in),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .bus            (bus_if),
    .mem_data_out   (mem_data_out),
    .mem_addr_out   (mem_addr_out),
    .stall_out      (stall_out),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus_if.mem_req && bus_if.mem_gnt) hs_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input data_t addr, input data_t sd);
    instr_t i;
    i = '0;
    i.opcode = op;
    i.funct3 = f3;
    instr_in       = i;
    alu_result_in  = addr;
    store_data_in  = sd;
    instr_valid_in = 1'b1;
  endtask

  task automatic quiet();
    instr_valid_in    = 1'b0;
    flush             = 1'b0;
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    quiet();
    bus_if.mem_rdata = '0;
    issue(OP_LOAD, F3_W, 32'h104, 32'h55);
    #2;
    check("rst_req",      32'(bus_if.mem_req), 32'd0);
    check("rst_stall",    32'(stall_out), 32'd0);
    check("rst_addr_out", mem_addr_out, 32'd0);
    check("rst_err",      32'(bus_err_out), 32'd0);
    check("rst_data",     mem_data_out, 32'd0);
    #20 rst_n = 1'b1;
    quiet();
    tick();

    // SW with immediate grant
    issue(OP_STORE, F3_W, 32'h100, 32'hDEADBEEF);
    bus_if.mem_gnt = 1'b1;
    #1;
    check("sw_req",   32'(bus_if.mem_req), 32'd1);
    check("sw_we",    32'(bus_if.mem_we), 32'd1);
    check("sw_be",    32'(bus_if.mem_be), 32'hF);
    check("sw_addr",  bus_if.mem_addr, 32'h100);
    check("sw_wdata", bus_if.mem_wdata, 32'hDEADBEEF);
    check("sw_stall", 32'(stall_out), 32'd0);
    tick();
    quiet();
    #1;
    check("sw_after_stall", 32'(stall_out), 32'd0);

    // LB / LBU from 0x103
    for (int k = 0; k < 2; k++) begin
      issue(OP_LOAD, (k == 0) ? F3_B : F3_BU, 32'h103, 32'h0);
      bus_if.mem_gnt = 1'b1;
      #1;
      check("lb_issue_stall", 32'(stall_out), 32'd1);
      check("lb_addr",        bus_if.mem_addr, 32'h100);
      tick();
      bus_if.mem_gnt    = 1'b0;
      bus_if.mem_rvalid = 1'b1;
      bus_if.mem_rdata  = 32'h80FF0000;
      #1;
      check("lb_rv_stall", 32'(stall_out), 32'd0);
      check("lb_rv_data",  mem_data_out, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
      tick();
      quiet();
      bus_if.mem_rdata = 32'h0;
      #1;
      check("lb_held_data", mem_data_out, (k == 0) ? 32'hFFFFFF80 : 32'h00000080);
    end

    // SH aligned and misaligned
    issue(OP_STORE, F3_H, 32'h102, 32'h00001234);
    bus_if.mem_gnt = 1'b1;
    #1;
    check("sh_be",    32'(bus_if.mem_be), 32'hC);
    check("sh_wdata", bus_if.mem_wdata, 32'h12341234);
    check("sh_stall", 32'(stall_out), 32'd0);
    tick();
    quiet();
    issue(OP_STORE, F3_H, 32'h101, 32'h00001234);
    #1;
    check("sh_mis",       32'(misaligned_out), 32'd1);
    check("sh_mis_req",   32'(bus_if.mem_req), 32'd0);
    check("sh_mis_stall", 32'(stall_out), 32'd0);
    tick();
    check("sh_mis_req2",  32'(bus_if.mem_req), 32'd0);
    quiet();
    tick();

    // LW, grant delayed 3 cycles, pipeline held 2 cycles after rvalid
    hs_base = hs_cnt;
    issue(OP_LOAD, F3_W, 32'h200, 32'h0);
    #1;
    check("lw_issue_req", 32'(bus_if.mem_req), 32'd1);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("lw_wait_req",   32'(bus_if.mem_req), 32'd1);
      check("lw_wait_stall", 32'(stall_out), 32'd1);
    end
    tick();
    bus_if.mem_gnt = 1'b1;
    #1;
    check("lw_gnt_stall", 32'(stall_out), 32'd1);
    tick();
    bus_if.mem_gnt    = 1'b0;
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'hCAFEF00D;
    en = 1'b0;
    #1;
    check("lw_rv_data",  mem_data_out, 32'hCAFEF00D);
    check("lw_rv_stall", 32'(stall_out), 32'd0);
    for (int c = 0; c < 2; c++) begin
      tick();
      bus_if.mem_rvalid = 1'b0;
      bus_if.mem_rdata  = 32'h11111111;
      #1;
      check("lw_done_state", 32'(dut.state), 32'(DONE));
      check("lw_done_data",  mem_data_out, 32'hCAFEF00D);
      check("lw_done_req",   32'(bus_if.mem_req), 32'd0);
      check("lw_done_stall", 32'(stall_out), 32'd0);
    end
    en = 1'b1;
    tick();
    quiet();
    check("lw_handshakes", 32'(hs_cnt - hs_base), 32'd1);
    check("lw_idle_state", 32'(dut.state), 32'(IDLE));

    // Load flushed while waiting for data
    issue(OP_LOAD, F3_W, 32'h300, 32'h0);
    bus_if.mem_gnt = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    flush = 1'b1;
    #1;
    check("fl_stall", 32'(stall_out), 32'd1);
    tick();
    quiet();
    #1;
    check("fl_drain_state", 32'(dut.state), 32'(DRAIN));
    check("fl_drain_stall", 32'(stall_out), 32'd1);
    tick();
    bus_if.mem_rvalid = 1'b1;
    bus_if.mem_rdata  = 32'hBAD0BAD0;
    #1;
    check("fl_rv_stall", 32'(stall_out), 32'd1);
    check("fl_rv_data",  mem_data_out, 32'hCAFEF00D);
    tick();
    quiet();
    #1;
    check("fl_idle_state", 32'(dut.state), 32'(IDLE));
    check("fl_idle_stall", 32'(stall_out), 32'd0);
    check("fl_idle_data",  mem_data_out, 32'hCAFEF00D);

    // Grant timeout with TIMEOUT_CYCLES = 4
    en = 1'b0;
    issue(OP_LOAD, F3_W, 32'h400, 32'h0);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("to_wait_req", 32'(bus_if.mem_req), 32'd1);
      check("to_wait_err", 32'(bus_err_out), 32'd0);
    end
    tick();
    check("to_req",   32'(bus_if.mem_req), 32'd0);
    check("to_err",   32'(bus_err_out), 32'd1);
    check("to_stall", 32'(stall_out), 32'd0);
    tick();
    check("to_err_held", 32'(bus_err_out), 32'd1);
    check("to_no_req",   32'(bus_if.mem_req), 32'd0);
    en = 1'b1;
    tick();
    quiet();
    #1;
    check("to_err_clr", 32'(bus_err_out), 32'd0);

    // Reset asserted while waiting for read data
    issue(OP_LOAD, F3_W, 32'h500, 32'h0);
    bus_if.mem_gnt = 1'b1;
    tick();
    bus_if.mem_gnt = 1'b0;
    #1;
    check("rr_state", 32'(dut.state), 32'(WAIT_RVALID));
    check("rr_stall", 32'(stall_out), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_req",      32'(bus_if.mem_req), 32'd0);
    check("rr_stall0",   32'(stall_out), 32'd0);
    check("rr_data",     mem_data_out, 32'd0);
    check("rr_addr_out", mem_addr_out, 32'd0);
    check("rr_addr",     bus_if.mem_addr, 32'd0);
    check("rr_err",      32'(bus_err_out), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
